// File: rtl/qsm_pkg.sv
// Shared state encoding and field widths for the QSM acquisition sequencer.
package qsm_pkg;

  localparam int FE_AW = 8;   // frontend address {dim, reg}
  localparam int DIM_W = 4;   // dimension index / count width
  localparam int REG_W = 4;   // register index width
  localparam int DLY_W = 10;  // read-delay width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STORE = 2'd3
  } qsm_state_t;

  // A zero read delay still needs one cycle to sample the frontend.
  function automatic logic [DLY_W-1:0] eff_delay(input logic [DLY_W-1:0] d);
    return (d == '0) ? DLY_W'(1) : d;
  endfunction

endpackage

// File: rtl/qsm_acq_seq_if.sv
// Frontend read port and readout-memory write port of the acquisition sequencer.
interface qsm_acq_seq_if #(
  parameter int DATA_W = 16,
  parameter int MEM_AW = 7
);
  import qsm_pkg::*;

  logic [DIM_W-1:0]  fe_dim_avail_i;
  logic              fe_rd_o;
  logic [FE_AW-1:0]  fe_adr_o;
  logic [DATA_W-1:0] fe_data_i;
  logic              fe_valid_i;
  logic              mem_we_o;
  logic [MEM_AW-1:0] mem_adr_o;
  logic [DATA_W-1:0] mem_dat_o;

  modport master (
    input  fe_dim_avail_i, fe_data_i, fe_valid_i,
    output fe_rd_o, fe_adr_o, mem_we_o, mem_adr_o, mem_dat_o
  );

  modport slave (
    output fe_dim_avail_i, fe_data_i, fe_valid_i,
    input  fe_rd_o, fe_adr_o, mem_we_o, mem_adr_o, mem_dat_o
  );

endinterface

// File: rtl/qsm_acq_wait_timer.sv
// Down-counter for the WAIT phase; expire marks the cycle the frontend is sampled.
module qsm_acq_wait_timer
  import qsm_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_load,
  input  logic             i_count,
  input  logic [DLY_W-1:0] i_load_val,
  output logic             o_expire
);

  logic [DLY_W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = i_count && (r_cnt == DLY_W'(1));

endmodule

// File: rtl/qsm_acq_seq.sv
// QSM acquisition sequencer: reads frontend words {dim,reg} and stores them to readout memory.
// Macro QSM_ACQ_FB_CHECK_EN: when defined, a word flagged invalid by the frontend aborts the run.
//
// state | meaning
// IDLE  | waiting for trigger, status held
// ISSUE | frontend read strobe for {dim,reg}
// WAIT  | read delay running, sample data on expiry
// STORE | write sampled word to memory, advance pointers
module qsm_acq_seq
  import qsm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MEM_AW = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ctrl_reset_i,
  input  logic             ctrl_trig_i,
  input  logic [REG_W-1:0] ctrl_last_reg_adr_i,
  input  logic [DIM_W-1:0] ctrl_max_dim_no_i,
  input  logic [DLY_W-1:0] ctrl_read_delay_i,
  output logic             sts_busy_o,
  output logic             sts_done_o,
  output logic             sts_err_many_o,
  output logic             sts_err_fb_o,
  output logic [DIM_W-1:0] sts_dim_count_o,
  qsm_acq_seq_if.master    bus
);

  qsm_state_t        r_state;
  logic              r_busy, r_done, r_err_many, r_err_fb, r_fe_rd, r_mem_we;
  logic [DIM_W-1:0]  r_nd, r_dim, r_dim_count;
  logic [REG_W-1:0]  r_reg;
  logic [MEM_AW-1:0] r_ptr;
  logic [DATA_W-1:0] r_mem_dat;

  logic              w_clr, w_too_many, w_last_reg, w_run_done, w_expire;
  logic              w_load, w_count;
  logic [DIM_W-1:0]  w_nd, w_dim_count_nxt;

  assign w_clr           = rst_i || ctrl_reset_i;
  assign w_too_many      = bus.fe_dim_avail_i > ctrl_max_dim_no_i;
  assign w_nd            = w_too_many ? ctrl_max_dim_no_i : bus.fe_dim_avail_i;
  assign w_last_reg      = (r_reg == ctrl_last_reg_adr_i);
  assign w_dim_count_nxt = r_dim_count + 1'b1;
  assign w_run_done      = w_last_reg && (w_dim_count_nxt == r_nd);
  assign w_load          = (r_state == ST_ISSUE);
  assign w_count         = (r_state == ST_WAIT);

  qsm_acq_wait_timer u_wait_timer (
    .clk_i      (clk_i),
    .rst_i      (w_clr),
    .i_load     (w_load),
    .i_count    (w_count),
    .i_load_val (eff_delay(ctrl_read_delay_i)),
    .o_expire   (w_expire)
  );

`ifndef QSM_ACQ_FB_CHECK_EN
  logic w_unused_valid;
  assign w_unused_valid = bus.fe_valid_i;
`endif

  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_many  <= 1'b0;
      r_err_fb    <= 1'b0;
      r_fe_rd     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_nd        <= '0;
      r_dim       <= '0;
      r_reg       <= '0;
      r_dim_count <= '0;
      r_ptr       <= '0;
      r_mem_dat   <= '0;
    end else begin
      r_fe_rd  <= 1'b0;
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ctrl_trig_i) begin
            r_done      <= (w_nd == '0);
            r_err_many  <= w_too_many;
            r_err_fb    <= 1'b0;
            r_dim_count <= '0;
            r_ptr       <= '0;
            r_dim       <= '0;
            r_reg       <= '0;
            r_nd        <= w_nd;
            if (w_nd != '0) begin
              r_state <= ST_ISSUE;
              r_busy  <= 1'b1;
              r_fe_rd <= 1'b1;
            end
          end
        end
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (w_expire) begin
            r_mem_dat <= bus.fe_data_i;
`ifdef QSM_ACQ_FB_CHECK_EN
            if (!bus.fe_valid_i) begin
              r_err_fb <= 1'b1;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= ST_IDLE;
            end else begin
              r_state  <= ST_STORE;
              r_mem_we <= 1'b1;
            end
`else
            r_state  <= ST_STORE;
            r_mem_we <= 1'b1;
`endif
          end
        end
        ST_STORE: begin
          r_ptr <= r_ptr + 1'b1;
          if (w_last_reg) begin
            r_reg       <= '0;
            r_dim       <= r_dim + 1'b1;
            r_dim_count <= w_dim_count_nxt;
          end else begin
            r_reg <= r_reg + 1'b1;
          end
          // Completion wins over a pointer wrap on the very last word.
          if (w_run_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (&r_ptr) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_err_many <= 1'b1;
          end else begin
            r_state <= ST_ISSUE;
            r_fe_rd <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sts_busy_o      = r_busy;
  assign sts_done_o      = r_done;
  assign sts_err_many_o  = r_err_many;
  assign sts_err_fb_o    = r_err_fb;
  assign sts_dim_count_o = r_dim_count;
  assign bus.fe_rd_o     = r_fe_rd;
  assign bus.fe_adr_o    = {r_dim, r_reg};
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_adr_o   = r_ptr;
  assign bus.mem_dat_o   = r_mem_dat;

endmodule
